// File: rtl/axi_modport_pkg.sv
// Shared types and constants for the AXI slave endpoint: burst encodings,
// response codes, bus widths and the per-channel FSM state enums.
package axi_modport_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for one AXI burst (FIXED / INCR / WRAP, reserved code acts as INCR).
// Purely combinational, no backpressure; WRAP assumes a power-of-two window.
module axi_burst_addr
   import axi_modport_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [2:0]        size,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr
);

   logic [1:0]        size_c;
   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] win_mask;
   logic [ADDR_W-1:0] sum;

   always_comb begin
      size_c   = (size > 3'd2) ? 2'd2 : size[1:0];
      step     = ADDR_W'(1) << size_c;
      win_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size_c) - ADDR_W'(1);
      sum      = addr + step;
      case (burst_t'(burst))
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~win_mask) | (sum & win_mask);
         default:     next_addr = sum;
      endcase
   end

endmodule

// File: rtl/axi_modport_slave.sv
// AXI slave with word-addressed memory; independent write/read channels, one burst each.
// R data one cycle after AR/R handshake, B one cycle after last W; AXI_SLV_ADDR_CHECK_EN flags out-of-range beats.
module axi_modport_slave
   import axi_modport_pkg::*;
#(
   parameter int ID_WIDTH  = 4,
   parameter int MEM_DEPTH = 256
)(
   input  logic                clock,
   input  logic                aresetn,
   input  logic [ID_WIDTH-1:0] awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [LEN_W-1:0]    awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [STRB_W-1:0]   wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_WIDTH-1:0] bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ID_WIDTH-1:0] arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [LEN_W-1:0]    arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_WIDTH-1:0] rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   wr_state_t         wstate, wstate_nxt;
   logic [ADDR_W-1:0] w_addr, w_addr_nxt;
   logic [LEN_W-1:0]  w_len, w_cnt;
   logic [2:0]        w_size;
   logic [1:0]        w_burst;
   logic              w_err, w_oob, w_last_beat, aw_hs, w_hs;

   rd_state_t         rstate, rstate_nxt;
   logic [ADDR_W-1:0] r_addr, r_addr_nxt, fetch_addr;
   logic [LEN_W-1:0]  r_len, r_cnt;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic              fetch_oob, ar_hs, r_hs;
   logic [DATA_W-1:0] fetch_data;

   assign aw_hs       = awvalid & awready;
   assign w_hs        = wvalid & wready;
   assign w_last_beat = (w_cnt == w_len);
   assign ar_hs       = arvalid & arready;
   assign r_hs        = rvalid & rready;
   assign fetch_addr  = ar_hs ? araddr : r_addr_nxt;
   assign fetch_data  = mem[fetch_addr[IDX_W+1:2]];
   assign bresp       = w_err ? RESP_SLVERR : RESP_OKAY;

`ifdef AXI_SLV_ADDR_CHECK_EN
   assign w_oob     = (w_addr >> 2) >= ADDR_W'(MEM_DEPTH);
   assign fetch_oob = (fetch_addr >> 2) >= ADDR_W'(MEM_DEPTH);
`else
   assign w_oob     = 1'b0;
   assign fetch_oob = 1'b0;
`endif

   // Only the word-index bits address the array; the rest feed the range check at most.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{w_addr[1:0], w_addr[ADDR_W-1:IDX_W+2],
                               fetch_addr[1:0], fetch_addr[ADDR_W-1:IDX_W+2]};

   axi_burst_addr u_waddr (.addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_addr_nxt));
   axi_burst_addr u_raddr (.addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_addr_nxt));

   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         wstate <= W_IDLE;
         rstate <= R_IDLE;
      end else begin
         wstate <= wstate_nxt;
         rstate <= rstate_nxt;
      end
   end

   // Ready on the address channels is gated by reset so nothing looks acceptable while held.
   always_comb begin
      wstate_nxt = wstate;
      awready    = 1'b0;
      wready     = 1'b0;
      bvalid     = 1'b0;
      case (wstate)
         W_IDLE: begin
            awready = aresetn;
            if (awvalid) wstate_nxt = W_DATA;
         end
         W_DATA: begin
            wready = 1'b1;
            if (wvalid && w_last_beat) wstate_nxt = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) wstate_nxt = W_IDLE;
         end
         default: wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      rstate_nxt = rstate;
      arready    = 1'b0;
      rvalid     = 1'b0;
      case (rstate)
         R_IDLE: begin
            arready = aresetn;
            if (arvalid) rstate_nxt = R_DATA;
         end
         R_DATA: begin
            rvalid = 1'b1;
            if (rready && rlast) rstate_nxt = R_IDLE;
         end
         default: rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         bid     <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
      end else if (aw_hs) begin
         bid     <= awid;
         w_addr  <= awaddr;
         w_len   <= awlen;
         w_size  <= awsize;
         w_burst <= awburst;
         w_cnt   <= '0;
         w_err   <= 1'b0;
      end else if (w_hs) begin
         w_addr <= w_addr_nxt;
         w_cnt  <= w_cnt + 1'b1;
         if ((wlast != w_last_beat) || w_oob) w_err <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_hs && !w_oob) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) mem[w_addr[IDX_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Read data is fetched on the handshake edge, so a same-cycle write is seen only afterwards.
   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         rid     <= '0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
         rlast   <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_cnt   <= '0;
      end else if (ar_hs) begin
         rid     <= arid;
         r_addr  <= araddr;
         r_len   <= arlen;
         r_size  <= arsize;
         r_burst <= arburst;
         r_cnt   <= '0;
         rlast   <= (arlen == '0);
         rdata   <= fetch_oob ? '0 : fetch_data;
         rresp   <= fetch_oob ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs) begin
         if (rlast) begin
            rlast <= 1'b0;
         end else begin
            r_addr <= r_addr_nxt;
            r_cnt  <= r_cnt + 1'b1;
            rlast  <= ((r_cnt + 1'b1) == r_len);
            rdata  <= fetch_oob ? '0 : fetch_data;
            rresp  <= fetch_oob ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

endmodule

// File: tb/tb_axi_modport_slave.sv
// Randomized bench for axi_modport_slave against a word-array reference model with
// per-beat address arithmetic; directed cases pin the model with literal values.
module tb_axi_modport_slave;

   logic        clock, aresetn;
   logic [3:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [3:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;

   axi_modport_slave dut (
      .clock(clock), .aresetn(aresetn),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   typedef struct {logic [31:0] data; logic last; logic [3:0] id; logic [1:0] resp;} rbeat_t;
   typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;

   rbeat_t      rexp_q[$];
   bexp_t       bexp_q[$];
   logic [31:0] obs_q[$];
   logic [31:0] mm [256];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [1:0]  last_bresp;
   logic [3:0]  last_bid;
   int          checks = 0;
   int          fails  = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
`ifdef AXI_SLV_ADDR_CHECK_EN
      return (a >> 2) < 256;
`else
      return 1'b1;
`endif
   endfunction

   // Address of beat i, computed directly from the burst start rather than stepwise.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                             input int size, input int burst, input int i);
      int unsigned bytes, win, base;
      bytes = 1 << ((size > 2) ? 2 : size);
      if (burst == 0) return start;
      if (burst == 2) begin
         win  = (len + 1) * bytes;
         base = (start / win) * win;
         return base + ((start - base + i * bytes) % win);
      end
      return start + i * bytes;
   endfunction

   // One compare process: whatever the DUT presents is checked against the model every cycle.
   always @(negedge clock) begin
      if (aresetn) begin
         if (rvalid) begin
            if (rexp_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL r_unexpected: rvalid=1 rdata=%h, expected no beat", rdata);
            end else begin
               chk("rdata", rdata, rexp_q[0].data);
               chk("rlast", rlast, rexp_q[0].last);
               chk("rid",   rid,   rexp_q[0].id);
               chk("rresp", rresp, rexp_q[0].resp);
               if (rready) begin
                  obs_q.push_back(rdata);
                  void'(rexp_q.pop_front());
               end
            end
         end
         if (bvalid) begin
            if (bexp_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL b_unexpected: bvalid=1 bresp=%h, expected no response", bresp);
            end else begin
               chk("bid",   bid,   bexp_q[0].id);
               chk("bresp", bresp, bexp_q[0].resp);
               if (bready) begin
                  last_bresp = bresp;
                  last_bid   = bid;
                  void'(bexp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic wait_hs(input int ch, input string name);
      bit ok;
      int n;
      n = 0;
      do begin
         @(negedge clock);
         case (ch)
            0: ok = awready;
            1: ok = wready;
            2: ok = arready;
            3: ok = rvalid;
            default: ok = bvalid;
         endcase
         @(posedge clock); #1;
         n++;
      end while (!ok && n < 64);
      chk(name, ok, 1);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int bad_last,
                           input int bdelay, input bit gaps);
      bexp_t       be;
      logic [31:0] a;
      bit          err, wl;
      err = 0;
      for (int i = 0; i <= len; i++) begin
         wl = (bad_last >= 0) ? (i == bad_last) : (i == len);
         if (wl != (i == len)) err = 1;
         if (!in_range(beat_addr(addr, len, size, burst, i))) err = 1;
      end
      be.id = id; be.resp = err ? 2'b10 : 2'b00;
      bexp_q.push_back(be);
      awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
      awvalid = 1;
      wait_hs(0, "aw_handshake");
      awvalid = 0;
      for (int i = 0; i <= len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
         wdata = wd[i]; wstrb = ws[i];
         wlast = (bad_last >= 0) ? (i == bad_last) : (i == len);
         wvalid = 1;
         wait_hs(1, "w_handshake");
         wvalid = 0;
         a = beat_addr(addr, len, size, burst, i);
         if (in_range(a))
            for (int b = 0; b < 4; b++)
               if (ws[i][b]) mm[(a >> 2) % 256][8*b +: 8] = wd[i][8*b +: 8];
      end
      @(negedge clock);
      chk("bvalid_after_last_beat", bvalid, 1);
      @(posedge clock); #1;
      repeat (bdelay) begin @(posedge clock); #1; end
      bready = 1;
      wait_hs(4, "b_handshake");
      bready = 0;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int stall_beat, input int stall);
      rbeat_t      rb;
      logic [31:0] a;
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, len, size, burst, i);
         rb.data = in_range(a) ? mm[(a >> 2) % 256] : 32'h0;
         rb.resp = in_range(a) ? 2'b00 : 2'b10;
         rb.last = (i == len);
         rb.id   = id;
         rexp_q.push_back(rb);
      end
      arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
      arvalid = 1;
      wait_hs(2, "ar_handshake");
      arvalid = 0;
      @(negedge clock);
      chk("rvalid_after_ar", rvalid, 1);
      @(posedge clock); #1;
      for (int i = 0; i <= len; i++) begin
         if (i == stall_beat) repeat (stall) begin @(posedge clock); #1; end
         rready = 1;
         wait_hs(3, "r_handshake");
         rready = 0;
      end
   endtask

   initial begin
      int len, size, burst;
      logic [31:0] addr;

      aresetn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
      wdata = 0; wstrb = 0; wlast = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_awready", awready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_wready",  wready,  0);
      chk("rst_bvalid",  bvalid,  0);
      chk("rst_rvalid",  rvalid,  0);
      chk("rst_rlast",   rlast,   0);
      chk("rst_rdata",   rdata,   0);
      chk("rst_bid_bresp", {bid, bresp}, 0);
      chk("rst_rid_rresp", {rid, rresp}, 0);
      @(posedge clock); #1;
      aresetn = 1;
      @(negedge clock);
      chk("post_rst_awready", awready, 1);
      @(posedge clock); #1;

      // Fill the whole array so every later read has a known value.
      for (int blk = 0; blk < 16; blk++) begin
         for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
         do_write(4'(blk), 32'(blk * 64), 15, 2, 1, -1, 0, 0);
      end

      chk("model_incr_addr", beat_addr(32'h10, 3, 2, 1, 3), 32'h1C);
      chk("model_wrap_addr", beat_addr(32'h18, 3, 2, 2, 2), 32'h10);

      // INCR write then read back with a 3-cycle rready stall and a 2-cycle bready stall.
      for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
      do_write(4'd5, 32'h10, 3, 2, 1, -1, 2, 0);
      chk("t1_bid_literal", last_bid, 5);
      chk("t1_bresp_literal", last_bresp, 0);
      obs_q.delete();
      do_read(4'd9, 32'h10, 3, 2, 1, 1, 3);
      chk("t1_beat_count", obs_q.size(), 4);
      for (int i = 0; i < obs_q.size(); i++) chk("t1_rdata_literal", obs_q[i], i + 1);

      // WRAP read over a window holding its own addresses.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h10 + 4 * i; ws[i] = 4'hF; end
      do_write(4'd1, 32'h10, 3, 2, 1, -1, 0, 0);
      obs_q.delete();
      do_read(4'd2, 32'h18, 3, 2, 2, -1, 0);
      chk("t2_beat_count", obs_q.size(), 4);
      if (obs_q.size() == 4) begin
         chk("t2_wrap_b0", obs_q[0], 32'h18);
         chk("t2_wrap_b1", obs_q[1], 32'h1C);
         chk("t2_wrap_b2", obs_q[2], 32'h10);
         chk("t2_wrap_b3", obs_q[3], 32'h14);
      end

      // Partial strobe merges into existing word.
      wd[0] = 32'h11223344; ws[0] = 4'hF;
      do_write(4'd3, 32'h40, 0, 2, 1, -1, 0, 0);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'b0011;
      do_write(4'd3, 32'h40, 0, 2, 1, -1, 0, 0);
      obs_q.delete();
      do_read(4'd4, 32'h40, 0, 2, 1, -1, 0);
      chk("t3_strobe_literal", (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD_BEEF, 32'h1122CCDD);

      // Early wlast: all four beats still taken, response flags the mismatch.
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(4'd6, 32'h80, 3, 2, 1, 1, 0, 0);
      chk("t4_wlast_bresp_literal", last_bresp, 2'b10);
      do_read(4'd6, 32'h80, 3, 2, 1, -1, 0);

      // Random bursts: write then read back the same footprint, plus independent reads.
      for (int it = 0; it < 40; it++) begin
         burst = $urandom_range(0, 3);
         len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
         size  = $urandom_range(0, 3);
         addr  = $urandom & 32'h7FF;
         for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
         do_write(4'($urandom), addr, len, size, burst, -1, $urandom_range(0, 2), 1);
         do_read(4'($urandom), addr, len, size, burst, $urandom_range(0, len), $urandom_range(0, 3));
         burst = $urandom_range(0, 3);
         len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
         do_read(4'($urandom), $urandom & 32'h7FF, len, $urandom_range(0, 3), burst,
                 $urandom_range(0, len), $urandom_range(0, 2));
      end

      // Reset in the middle of a read burst.
      for (int i = 0; i < 8; i++) begin
         rexp_q.push_back('{data: mm[(32'h100 >> 2) + i], last: (i == 7), id: 4'd7, resp: 2'b00});
      end
      arid = 4'd7; araddr = 32'h100; arlen = 4'd7; arsize = 3'd2; arburst = 2'd1;
      arvalid = 1;
      wait_hs(2, "t5_ar_handshake");
      arvalid = 0;
      rready = 1;
      wait_hs(3, "t5_r_handshake");
      rready = 0;
      #2 aresetn = 0;
      #1;
      chk("t5_rvalid_in_reset", rvalid, 0);
      chk("t5_rlast_in_reset", rlast, 0);
      chk("t5_rdata_in_reset", rdata, 0);
      chk("t5_arready_in_reset", arready, 0);
      rexp_q.delete();
      @(posedge clock); #1;
      aresetn = 1;
      @(negedge clock);
      chk("t5_arready_after_release", arready, 1);
      chk("t5_rvalid_after_release", rvalid, 0);
      @(posedge clock); #1;
      do_read(4'd8, 32'h100, 7, 2, 1, -1, 0);

      repeat (2) @(posedge clock);
      chk("rexp_drained", rexp_q.size(), 0);
      chk("bexp_drained", bexp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
